// File: rtl/line_buf_pkg.sv
// Shared constants, state encoding and width helpers for the line buffer sequencer.
package line_buf_pkg;

  localparam int WIDTH      = 640;
  localparam int HEIGHT     = 480;
  localparam int DATA_W     = 30;
  localparam int CENTER_LAG = 2 * WIDTH - 2;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int X_W = cnt_w(WIDTH);
  localparam int Y_W = cnt_w(HEIGHT);
  localparam int N_W = cnt_w(WIDTH * HEIGHT + CENTER_LAG);

endpackage

// File: rtl/line_buffer_ctrl_if.sv
// Pixel stream handshake into the line buffer sequencer.
interface line_buffer_ctrl_if #(
  parameter int PIX_W = line_buf_pkg::DATA_W
) ();

  logic             in_valid;
  logic             in_sof;
  logic [PIX_W-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_sof, output in_data, input in_ready);
  modport slave  (input in_valid, input in_sof, input in_data, output in_ready);

endinterface

// File: rtl/line_buffer_ctrl_window_pos_counter.sv
// Centre-pixel coordinate tracker: x/y counters that step once per new window,
// plus the registered window-valid and border flags that travel with them.
module window_pos_counter
  import line_buf_pkg::*;
#(
  parameter int FRAME_W = WIDTH,
  parameter int FRAME_H = HEIGHT
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        win_stb,    // a shift is producing a frame-pixel window
  input  logic                        win_first,  // that window is pixel 0 of the frame
  output logic                        grid_valid,
  output logic [cnt_w(FRAME_W)-1:0]   center_x,
  output logic [cnt_w(FRAME_H)-1:0]   center_y,
  output logic                        border
);

  localparam int XW = cnt_w(FRAME_W);
  localparam int YW = cnt_w(FRAME_H);
  localparam logic [XW-1:0] X_LAST = XW'(FRAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          border_q, border_d;
  logic          valid_q, valid_d;

  // Next coordinates: restart at the first window, otherwise raster-step; hold when idle.
  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    border_d = border_q;
    valid_d  = win_stb;
    if (win_stb) begin
      if (win_first) begin
        x_d = '0;
        y_d = '0;
      end else if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      border_d = (x_d == '0) || (x_d == X_LAST) || (y_d == '0) || (y_d == Y_LAST);
    end
  end

  // Coordinate, border and valid registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q      <= '0;
      y_q      <= '0;
      border_q <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      x_q      <= x_d;
      y_q      <= y_d;
      border_q <= border_d;
      valid_q  <= valid_d;
    end
  end

  assign grid_valid = valid_q;
  assign center_x   = x_q;
  assign center_y   = y_q;
  assign border     = border_q;

endmodule

// File: rtl/line_buffer_ctrl.sv
// Sequencer for a 3-line sliding-window buffer: feeds pixels in, flushes the
// tail of each frame with zeros, and tags every window whose centre is a real
// frame pixel with its coordinates and border status.
module line_buffer_ctrl
  import line_buf_pkg::*;
#(
  parameter int FRAME_W = WIDTH,
  parameter int FRAME_H = HEIGHT,
  parameter int PIX_W   = DATA_W
) (
  input  logic                      clock,
  input  logic                      reset_n,
  line_buffer_ctrl_if.slave         pix,
  output logic                      buf_clken,
  output logic [PIX_W-1:0]          buf_shiftin,
  output logic                      grid_valid,
  output logic [cnt_w(FRAME_W)-1:0] center_x,
  output logic [cnt_w(FRAME_H)-1:0] center_y,
  output logic                      border,
  output logic                      frame_done,
  output logic                      sof_err
);

  localparam int TOTAL = FRAME_W * FRAME_H;
  localparam int LAG   = 2 * FRAME_W - 2;
  localparam int NW    = cnt_w(TOTAL + LAG);
  localparam logic [NW-1:0] LAST_PIX   = NW'(TOTAL - 1);
  localparam logic [NW-1:0] LAST_SHIFT = NW'(TOTAL + LAG - 1);
  localparam logic [NW-1:0] LAG_N      = NW'(LAG);

  state_e        state_q, state_d;
  logic [NW-1:0] n_q, n_d;
  logic [NW-1:0] n_cur;       // index of the shift happening this cycle
  logic          sof_err_q, sof_err_d;
  logic          shift;

  // Next-state, shift strobe and stream-side outputs.
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    n_cur        = n_q;
    sof_err_d    = sof_err_q;
    shift        = 1'b0;
    pix.in_ready = 1'b1;
    buf_shiftin  = pix.in_data;
    frame_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pix.in_valid) begin
          if (pix.in_sof) begin
            shift   = 1'b1;
            n_cur   = '0;
            state_d = STREAM;
          end else begin
            // Pixel with no frame context is swallowed, never shifted.
            sof_err_d = 1'b1;
          end
        end
      end
      STREAM: begin
        if (pix.in_valid) begin
          shift = 1'b1;
          if (pix.in_sof) begin
            // Abort the running frame; this pixel starts a new one, and
            // restarting n below the lag suppresses stale windows.
            n_cur     = '0;
            sof_err_d = 1'b1;
          end
        end
      end
      FLUSH: begin
        pix.in_ready = 1'b0;
        shift        = 1'b1;
        buf_shiftin  = '0;
        if (n_q == LAST_SHIFT) state_d = DONE;
      end
      DONE: begin
        pix.in_ready = 1'b0;
        frame_done   = 1'b1;
        n_d          = '0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (shift) n_d = n_cur + 1'b1;
    if (shift && (state_q != FLUSH) && (n_cur == LAST_PIX)) state_d = FLUSH;
  end

  // Control registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      n_q       <= '0;
      sof_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      sof_err_q <= sof_err_d;
    end
  end

  assign buf_clken = shift;
  assign sof_err   = sof_err_q;

  window_pos_counter #(
    .FRAME_W (FRAME_W),
    .FRAME_H (FRAME_H)
  ) u_pos (
    .clock      (clock),
    .reset_n    (reset_n),
    .win_stb    (shift && (n_cur >= LAG_N)),
    .win_first  (n_cur == LAG_N),
    .grid_valid (grid_valid),
    .center_x   (center_x),
    .center_y   (center_y),
    .border     (border)
  );

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl on an 8x4 frame: a directed vector
// table for the stream start, then model-checked frames covering gaps,
// pre-sof pixels, mid-frame sof, reset during flush and random traffic.
module tb_line_buffer_ctrl;
  import line_buf_pkg::*;

  localparam int W     = 8;
  localparam int H     = 4;
  localparam int PW    = 30;
  localparam int TOTAL = W * H;
  localparam int LAG   = 2 * W - 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          buf_clken;
  logic [PW-1:0] buf_shiftin;
  logic          grid_valid;
  logic [2:0]    center_x;
  logic [1:0]    center_y;
  logic          border;
  logic          frame_done;
  logic          sof_err;

  always #5 clock = ~clock;

  line_buffer_ctrl_if #(.PIX_W(PW)) pix ();

  line_buffer_ctrl #(.FRAME_W(W), .FRAME_H(H), .PIX_W(PW)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pix         (pix),
    .buf_clken   (buf_clken),
    .buf_shiftin (buf_shiftin),
    .grid_valid  (grid_valid),
    .center_x    (center_x),
    .center_y    (center_y),
    .border      (border),
    .frame_done  (frame_done),
    .sof_err     (sof_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of pixels accepted, flush length and errors.
  bit            m_in_frame;
  int            m_n;
  int            m_flush_left;
  bit            m_done;
  bit            m_err;
  bit            win_pend;
  int            win_m;
  logic [PW-1:0] pixq[$];
  logic [PW-1:0] hist[$];
  int            seen_win;
  int            seen_nb;

  function automatic void model_reset();
    m_in_frame   = 1'b0;
    m_n          = 0;
    m_flush_left = 0;
    m_done       = 1'b0;
    m_err        = 1'b0;
    win_pend     = 1'b0;
    win_m        = 0;
    pixq.delete();
    hist.delete();
    seen_win     = 0;
    seen_nb      = 0;
  endfunction

  task automatic cycle(input bit v, input bit s, input logic [PW-1:0] d);
    bit            e_ready, e_fd, e_shift, new_frame;
    logic [PW-1:0] e_data;
    @(negedge clock);
    pix.in_valid = v;
    pix.in_sof   = s;
    pix.in_data  = d;
    #1;
    e_ready   = !(m_flush_left > 0 || m_done);
    e_fd      = m_done;
    e_shift   = 1'b0;
    e_data    = '0;
    new_frame = 1'b0;
    if (m_done) m_done = 1'b0;
    else if (m_flush_left > 0) e_shift = 1'b1;
    else if (v && s) begin
      if (m_in_frame) m_err = 1'b1;
      new_frame = 1'b1;
      e_shift   = 1'b1;
      e_data    = d;
    end else if (v && m_in_frame) begin
      e_shift = 1'b1;
      e_data  = d;
    end else if (v) m_err = 1'b1;

    chk("in_ready", pix.in_ready, e_ready);
    chk("buf_clken", buf_clken, e_shift);
    if (e_shift) chk("buf_shiftin", buf_shiftin, e_data);
    chk("frame_done", frame_done, e_fd);
    if (e_fd) begin
      chk("windows_per_frame", seen_win, TOTAL);
      chk("interior_windows", seen_nb, (W - 2) * (H - 2));
    end

    if (new_frame) begin
      m_in_frame = 1'b1;
      m_n        = 0;
      pixq.delete();
      hist.delete();
      seen_win   = 0;
      seen_nb    = 0;
    end
    if (e_shift) begin
      hist.push_back(buf_shiftin);
      if (m_flush_left == 0) pixq.push_back(d);
      win_pend = (m_n >= LAG);
      win_m    = m_n - LAG;
      m_n++;
      if (m_flush_left > 0) begin
        m_flush_left--;
        if (m_flush_left == 0) m_done = 1'b1;
      end else if (pixq.size() == TOTAL) begin
        m_in_frame   = 1'b0;
        m_flush_left = LAG;
      end
    end else begin
      win_pend = 1'b0;
    end

    @(posedge clock);
    #1;
    chk("grid_valid", grid_valid, win_pend);
    if (win_pend && grid_valid) begin
      chk("center_x", center_x, win_m % W);
      chk("center_y", center_y, win_m / W);
      chk("border", border, (win_m % W == 0) || (win_m % W == W - 1) ||
                            (win_m / W == 0) || (win_m / W == H - 1));
      chk("centre_tap", hist[win_m], pixq[win_m]);
    end
    if (grid_valid) begin
      seen_win++;
      if (!border) seen_nb++;
    end
    chk("sof_err", sof_err, m_err);
  endtask

  // mode 0: back-to-back, 1: valid toggling 1,0,1,0, 2: random idle gaps
  task automatic send_frame(input int mode);
    for (int i = 0; i < TOTAL; i++) begin
      cycle(1'b1, i == 0, PW'($urandom));
      if (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0))
        cycle(1'b0, 1'b0, PW'($urandom));
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 * LAG; i++) begin
      if (m_flush_left == 0 && !m_done) break;
      cycle(1'b0, 1'b0, '0);
    end
    chk("drain_bound", (m_flush_left > 0) || m_done, 1'b0);
    cycle(1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    pix.in_valid = 1'b0;
    pix.in_sof   = 1'b0;
    reset_n      = 1'b0;
    #1;
    chk("rst_in_ready", pix.in_ready, 1'b1);
    chk("rst_buf_clken", buf_clken, 1'b0);
    chk("rst_grid_valid", grid_valid, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_sof_err", sof_err, 1'b0);
    chk("rst_center_x", center_x, 0);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit            v;
    bit            s;
    logic [PW-1:0] d;
    bit            rdy;
    bit            clken;
    bit            err;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pix.in_valid = 1'b0;
    pix.in_sof   = 1'b0;
    pix.in_data  = '0;
    model_reset();

    // Reset state with reset held.
    repeat (2) @(negedge clock);
    #1;
    chk("init_in_ready", pix.in_ready, 1'b1);
    chk("init_buf_clken", buf_clken, 1'b0);
    chk("init_grid_valid", grid_valid, 1'b0);
    chk("init_frame_done", frame_done, 1'b0);
    chk("init_sof_err", sof_err, 1'b0);
    @(negedge clock);
    reset_n = 1'b1;

    // Directed start-of-stream vectors: {valid, sof, data, ready, clken, sof_err after edge}.
    tbl[0] = '{1'b0, 1'b0, 30'h0,   1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 30'hAA,  1'b1, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 30'hBB,  1'b1, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 30'h123, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 30'hCC,  1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b1, 1'b0, 30'hDD,  1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      pix.in_valid = tbl[i].v;
      pix.in_sof   = tbl[i].s;
      pix.in_data  = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_in_ready", i), pix.in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_buf_clken", i), buf_clken, tbl[i].clken);
      if (tbl[i].clken) chk($sformatf("tbl%0d_buf_shiftin", i), buf_shiftin, tbl[i].d);
      @(posedge clock);
      #1;
      chk($sformatf("tbl%0d_sof_err", i), sof_err, tbl[i].err);
      chk($sformatf("tbl%0d_grid_valid", i), grid_valid, 1'b0);
    end
    do_reset();

    // Gap-free frame, then the same frame with valid toggling.
    send_frame(0);
    drain();
    send_frame(1);
    drain();

    // Pixels before any sof, then a normal frame.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, PW'($urandom));
    send_frame(0);
    drain();
    do_reset();

    // Second sof at pixel 20 aborts the frame; the restarted frame completes.
    for (int i = 0; i < 20; i++) cycle(1'b1, i == 0, PW'($urandom));
    send_frame(0);
    drain();
    do_reset();

    // Reset during flush, then a clean frame.
    send_frame(0);
    repeat (5) cycle(1'b0, 1'b0, '0);
    do_reset();
    send_frame(2);
    drain();

    // Random traffic with occasional stray sof.
    for (int f = 0; f < 6; f++) begin
      cycle(1'b1, 1'b1, PW'($urandom));
      for (int k = 0; k < 400 && m_in_frame; k++)
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 60) == 0, PW'($urandom));
      chk("random_frame_bound", m_in_frame, 1'b0);
      drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/line_buffer_ctrl.md
Name: line_buffer_ctrl

Overview:
Sequencer for the 3-line, 640-tap edge-detection line buffer. It accepts a pixel stream with start-of-frame marking and drives the buffer's clock-enable and shift-in data. It tracks the buffer's fill level and tags each valid 3x3 window with the coordinates and border status of its centre pixel. At end of frame it flushes the buffer with zero pixels, so the bottom rows' windows are emitted before the next frame is accepted.

Parameters:
WIDTH, 640, pixels per line; must equal the buffer's line length.
HEIGHT, 480, lines per frame.
DATA_W, 30, pixel width (10b R/G/B).
CENTER_LAG, 2*WIDTH-2, shifts between a pixel entering the buffer and that pixel reaching the window centre tap.

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  in_data/in_sof valid this cycle
in_sof  in  1  first pixel of frame (qualified by in_valid)
in_data  in  DATA_W  pixel
in_ready  out  1  controller accepts a pixel this cycle
buf_clken  out  1  to buffer clken
buf_shiftin  out  DATA_W  to buffer shiftin
grid_valid  out  1  buffer window is new and its centre is a frame pixel
center_x  out  clog2(WIDTH)  column of window centre
center_y  out  clog2(HEIGHT)  row of window centre
border  out  1  centre on row 0, row HEIGHT-1, col 0 or col WIDTH-1 (neighbours invalid)
frame_done  out  1  one-cycle pulse, all windows of frame emitted
sof_err  out  1  sticky: in_sof seen mid-frame or pixel arrived before in_sof; cleared only by reset

Behaviour:
- Reset (async assert, sync deassert by system):
  - state=IDLE.
  - All outputs 0 except in_ready=1.
  - Counters 0.
  - Buffer contents are not cleared; stale data is never flagged valid.
- States:
  - IDLE:
    - in_ready=1.
    - in_valid&in_sof: shift pixel as index n=0, go STREAM.
    - in_valid&!in_sof: pixel accepted but not shifted (buf_clken=0); set sof_err.
  - STREAM:
    - in_ready=1.
    - buf_clken = in_valid; buf_shiftin = in_data.
    - Each accepted pixel increments n.
    - On acceptance of n=WIDTH*HEIGHT-1, go FLUSH.
  - FLUSH:
    - in_ready=0.
    - buf_clken=1 every cycle; buf_shiftin=0.
    - Exactly CENTER_LAG shifts, then go DONE.
  - DONE:
    - in_ready=0; frame_done=1 for one cycle.
    - Go IDLE.
- in_sof with in_valid while in STREAM: set sof_err; restart n=0 with this pixel; centre counters reset; no windows from the aborted frame are emitted after it.
- Shift index n counts shifts since the frame's first pixel, including flush shifts. Width is clog2(WIDTH*HEIGHT+CENTER_LAG).
- A window is new the cycle after a shift. grid_valid is registered: high in cycle t+1 iff a shift occurred in cycle t and n(t) >= CENTER_LAG.
  - The window centre is then frame pixel m = n-CENTER_LAG.
  - Over STREAM+FLUSH, m covers 0..WIDTH*HEIGHT-1 exactly once.
- center_x/center_y:
  - Incrementing counters, no divider.
  - They advance on each window after the first.
  - x wraps at WIDTH-1 to 0 and increments y.
  - They are registered alongside grid_valid and hold their value when grid_valid=0.
- border is registered with grid_valid. Taps from the neighbouring line wrap and are not valid image neighbours at the border; downstream must use border to suppress or clamp those windows.
- No backpressure from downstream: grid_valid may be high on consecutive cycles, and throughout FLUSH.
- Reset mid-frame returns to IDLE immediately; the next frame requires in_sof.

Decomposition:
- Shared package line_buf_pkg holds:
  - WIDTH, HEIGHT, DATA_W, CENTER_LAG;
  - the state enum {IDLE, STREAM, FLUSH, DONE};
  - the counter-width constants.
- One natural sub-module, window_pos_counter: the x/y centre counters with wrap and border generation, enabled by the delayed shift strobe.

Test Plan:
- WIDTH=8, HEIGHT=4 (CENTER_LAG=14); 32 back-to-back pixels with sof on the first -> 14 FLUSH cycles with in_ready=0, then exactly 32 grid_valid pulses. The first pulse is the cycle after the 15th shift with (x,y)=(0,0). Then 12 non-border windows, then frame_done one cycle after the last flush shift.
- Same frame with in_valid toggling 1,0,1,0 -> buf_clken mirrors in_valid; grid_valid only follows shifts; coordinate sequence identical to the gap-free case.
- Pixels before any in_sof -> buf_clken=0 and sof_err=1; a subsequent sof frame completes normally.
- Second in_sof at pixel 20 of a frame -> sof_err=1; that pixel becomes n=0; the following frame yields exactly 32 windows starting at (0,0).
- reset_n low for 1 cycle during FLUSH -> all outputs reset at once, in_ready=1, no frame_done; next frame is correct.
- Default 640x480 frame against a reference 3-line buffer model -> 307200 windows; centre tap equals pixel m for every window; frame_done after 1278 flush cycles.
